// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder datapath stages.
package adder_pkg;

  // Frame accumulator control states.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_e;

  // Width of one adder result {Carry, Sum}.
  localparam int SAMPLE_W = 3;

  // Widest accumulator the shared saturating add supports.
  localparam int SAT_MAX_W = 32;

  // Saturating add of two w-bit operands carried in SAT_MAX_W-bit containers.
  // Operands must already be below 2**w. The result is at most w bits wide,
  // and bit SAT_MAX_W flags that the w+1-bit sum overflowed and was clamped.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [SAT_MAX_W:0] raw;
    logic [SAT_MAX_W:0] ones;
    logic [SAT_MAX_W:0] hi;
    raw  = {1'b0, a} + {1'b0, b};
    ones = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    // Inputs are below 2**w, so anything left above bit w-1 is the carry.
    hi   = raw >> w;
    if (hi != '0) sat_add = ones | {1'b1, {SAT_MAX_W{1'b0}}};
    else          sat_add = raw;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational ACC_W-bit saturating adder with a carry-out (saturated) flag.
module sat_adder
  import adder_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [SAT_MAX_W:0] full;

  // Widen into the shared helper, then keep the ACC_W result and the flag.
  always_comb begin
    full = sat_add(SAT_MAX_W'(a), SAT_MAX_W'(b), ACC_W);
  end

  assign sum   = full[ACC_W-1:0];
  assign carry = full[SAT_MAX_W];

endmodule

// File: rtl/adder_result_accumulator.sv
// Sums COUNT adder results per frame into a saturating total and holds the
// total on a valid/ready port until the consumer takes it.
module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_valid,
  input  logic             Carry,
  input  logic [1:0]       Sum,
  output logic             In_ready,
  output logic [ACC_W-1:0] Total,
  output logic             Overflow,
  output logic             Out_valid,
  input  logic             Out_ready
);

  localparam int CNT_W_RAW = $clog2(COUNT + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  acc_state_e       state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sample;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             ovf_sticky;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

  assign sample = ACC_W'({Carry, Sum});
  assign accept = In_valid && In_ready;
  assign last   = (cnt == CNT_LAST);

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .a     (acc),
    .b     (sample),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  // Next state: close the frame on the last accept, reopen on output handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = DONE;
      DONE:    if (Out_ready)      state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Handshake outputs decode from state only, so no input-to-ready path exists.
  always_comb begin
    In_ready  = 1'b0;
    Out_valid = 1'b0;
    case (state)
      ACCUM:   In_ready  = 1'b1;
      DONE:    Out_valid = 1'b1;
      default: In_ready  = 1'b1;
    endcase
  end

  // Accumulator, counter and output registers; Total/Overflow load only on frame close.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      Total      <= '0;
      Overflow   <= 1'b0;
    end else if (accept) begin
      if (last) begin
        Total      <= add_sum;
        Overflow   <= ovf_sticky | add_carry;
        acc        <= '0;
        cnt        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= add_sum;
        cnt        <= cnt + CNT_W'(1);
        ovf_sticky <= ovf_sticky | add_carry;
      end
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: three instances (default, ACC_W=4,
// COUNT=1) driven one at a time against a behavioural frame model.
module tb_adder_result_accumulator;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst;
  logic [2:0] iv, cy, ordy;
  logic [1:0] sm [3];
  logic [2:0] irdy, ovl, ovf;
  logic [7:0] t0;
  logic [3:0] t1;
  logic [7:0] t2;

  adder_result_accumulator #(.COUNT(4), .ACC_W(8)) dut0 (
    .Clk(Clk), .Reset(rst), .In_valid(iv[0]), .Carry(cy[0]), .Sum(sm[0]),
    .In_ready(irdy[0]), .Total(t0), .Overflow(ovf[0]), .Out_valid(ovl[0]), .Out_ready(ordy[0]));
  adder_result_accumulator #(.COUNT(4), .ACC_W(4)) dut1 (
    .Clk(Clk), .Reset(rst), .In_valid(iv[1]), .Carry(cy[1]), .Sum(sm[1]),
    .In_ready(irdy[1]), .Total(t1), .Overflow(ovf[1]), .Out_valid(ovl[1]), .Out_ready(ordy[1]));
  adder_result_accumulator #(.COUNT(1), .ACC_W(8)) dut2 (
    .Clk(Clk), .Reset(rst), .In_valid(iv[2]), .Carry(cy[2]), .Sum(sm[2]),
    .In_ready(irdy[2]), .Total(t2), .Overflow(ovf[2]), .Out_valid(ovl[2]), .Out_ready(ordy[2]));

  typedef struct {
    logic [7:0] tot;
    logic       ovf;
  } exp_t;

  exp_t sbq [3][$];
  int   m_sum [3];
  int   m_cnt [3];
  bit   m_done [3];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seen_n;
  logic [7:0] seen_tot;
  logic       seen_ovf;

  function automatic int cnt_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int max_of(input int k);
    return (k == 1) ? 15 : 255;
  endfunction

  function automatic logic [7:0] tot_of(input int k);
    case (k)
      0:       return t0;
      1:       return {4'b0000, t1};
      default: return t2;
    endcase
  endfunction

  task automatic drive(input int k, input bit vld, input int v, input bit rdy);
    iv[k]           = vld;
    {cy[k], sm[k]}  = 3'(v);
    ordy[k]         = rdy;
  endtask

  // One clock: advance every instance's frame model on the edge, then let
  // outputs settle and note any valid output of instance k.
  task automatic step(input int k);
    exp_t e;
    @(posedge Clk);
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        sbq[j].delete();
        m_done[j] = 0; m_sum[j] = 0; m_cnt[j] = 0;
      end else if (m_done[j]) begin
        if (ordy[j]) begin
          void'(sbq[j].pop_front());
          m_done[j] = 0;
        end
      end else if (iv[j]) begin
        m_sum[j] += int'({cy[j], sm[j]});
        m_cnt[j]++;
        if (m_cnt[j] == cnt_of(j)) begin
          e.ovf = (m_sum[j] > max_of(j));
          e.tot = e.ovf ? 8'(max_of(j)) : 8'(m_sum[j]);
          sbq[j].push_back(e);
          m_done[j] = 1; m_sum[j] = 0; m_cnt[j] = 0;
        end
      end
    end
    #1;
    if (ovl[k]) begin
      seen_n++;
      seen_tot = tot_of(k);
      seen_ovf = ovf[k];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) drive(j, 1'b1, 7, 1'b1);
    step(0);
    step(0);
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (irdy[j] !== 1'b1 || ovl[j] !== 1'b0 || tot_of(j) !== 8'd0 || ovf[j] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_in[%0d] rdy/vld/tot/ovf=%b/%b/%0d/%b need 1/0/0/0", j, irdy[j], ovl[j], tot_of(j), ovf[j]);
      end
    end
    rst = 1'b0;
    for (int j = 0; j < 3; j++) drive(j, 1'b0, 0, 1'b1);
    step(0);
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (irdy[j] !== 1'b1 || ovl[j] !== 1'b0 || tot_of(j) !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_after[%0d] rdy/vld/tot=%b/%b/%0d need 1/0/0", j, irdy[j], ovl[j], tot_of(j));
      end
    end
  endtask

  task automatic test_basic();
    int s [6] = '{1, 2, 3, 6, 0, 0};
    bit v [6] = '{1, 1, 1, 1, 0, 0};
    seen_n = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, v[i], s[i], 1'b1);
      step(0);
      n_cmp++;
      if (ovl[0] !== m_done[0] || irdy[0] !== !m_done[0]) begin
        n_bad++;
        $display("FAIL basic_hs[%0d] vld/rdy=%b/%b need %b/%b", i, ovl[0], irdy[0], m_done[0], !m_done[0]);
      end
      if (m_done[0]) begin
        n_cmp++;
        if (tot_of(0) !== sbq[0][0].tot || ovf[0] !== sbq[0][0].ovf) begin
          n_bad++;
          $display("FAIL basic_sb[%0d] tot/ovf=%0d/%b need %0d/%b", i, tot_of(0), ovf[0], sbq[0][0].tot, sbq[0][0].ovf);
        end
      end
    end
    n_cmp++;
    if (seen_n !== 1 || seen_tot !== 8'd12 || seen_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_total cycles/tot/ovf=%0d/%0d/%b need 1/12/0", seen_n, seen_tot, seen_ovf);
    end
  endtask

  task automatic test_saturate();
    int s [10] = '{6, 6, 6, 0, 0, 1, 1, 1, 1, 0};
    bit v [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [7:0] ft [2];
    logic       fo [2];
    int         nf = 0;
    for (int i = 0; i < 10; i++) begin
      seen_n = 0;
      drive(1, v[i], s[i], 1'b1);
      step(1);
      n_cmp++;
      if (ovl[1] !== m_done[1] || irdy[1] !== !m_done[1]) begin
        n_bad++;
        $display("FAIL sat_hs[%0d] vld/rdy=%b/%b need %b/%b", i, ovl[1], irdy[1], m_done[1], !m_done[1]);
      end
      if (m_done[1]) begin
        n_cmp++;
        if (tot_of(1) !== sbq[1][0].tot || ovf[1] !== sbq[1][0].ovf) begin
          n_bad++;
          $display("FAIL sat_sb[%0d] tot/ovf=%0d/%b need %0d/%b", i, tot_of(1), ovf[1], sbq[1][0].tot, sbq[1][0].ovf);
        end
      end
      if (seen_n > 0 && nf < 2) begin
        ft[nf] = seen_tot; fo[nf] = seen_ovf; nf++;
      end
    end
    n_cmp++;
    if (nf !== 2 || ft[0] !== 8'd15 || fo[0] !== 1'b1 || ft[1] !== 8'd4 || fo[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_frames n=%0d tot/ovf=%0d/%b,%0d/%b need 2 15/1,4/0", nf, ft[0], fo[0], ft[1], fo[1]);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 2, 1'b0);
      step(0);
    end
    // Stalled output: incoming results must be refused and the total held.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 7, 1'b0);
      step(0);
      n_cmp++;
      if (ovl[0] !== 1'b1 || irdy[0] !== 1'b0 || tot_of(0) !== 8'd8 || ovf[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] vld/rdy/tot/ovf=%b/%b/%0d/%b need 1/0/8/0", i, ovl[0], irdy[0], tot_of(0), ovf[0]);
      end
      n_cmp++;
      if (m_done[0] && tot_of(0) !== sbq[0][0].tot) begin
        n_bad++;
        $display("FAIL bp_sb[%0d] tot=%0d need %0d", i, tot_of(0), sbq[0][0].tot);
      end
    end
    drive(0, 1'b0, 0, 1'b1);
    step(0);
    n_cmp++;
    if (ovl[0] !== 1'b0 || irdy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release vld/rdy=%b/%b need 0/1", ovl[0], irdy[0]);
    end
    seen_n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, i < 4, 1, 1'b1);
      step(0);
    end
    n_cmp++;
    if (seen_n !== 1 || seen_tot !== 8'd4 || seen_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_next cycles/tot/ovf=%0d/%0d/%b need 1/4/0", seen_n, seen_tot, seen_ovf);
    end
  endtask

  task automatic test_gaps();
    int s [8] = '{5, 7, 7, 4, 7, 3, 2, 0};
    bit v [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    seen_n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, v[i], s[i], 1'b1);
      step(0);
      n_cmp++;
      if (ovl[0] !== (i == 6)) begin
        n_bad++;
        $display("FAIL gaps_vld[%0d] Out_valid=%b need %b", i, ovl[0], (i == 6));
      end
      if (m_done[0]) begin
        n_cmp++;
        if (tot_of(0) !== sbq[0][0].tot || ovf[0] !== sbq[0][0].ovf) begin
          n_bad++;
          $display("FAIL gaps_sb[%0d] tot/ovf=%0d/%b need %0d/%b", i, tot_of(0), ovf[0], sbq[0][0].tot, sbq[0][0].ovf);
        end
      end
    end
    n_cmp++;
    if (seen_tot !== 8'd14 || seen_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL gaps_total tot/ovf=%0d/%b need 14/0", seen_tot, seen_ovf);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 3, 1'b1); step(0);
    drive(0, 1'b1, 3, 1'b1); step(0);
    rst = 1'b1;
    drive(0, 1'b0, 0, 1'b1);
    step(0);
    rst = 1'b0;
    n_cmp++;
    if (ovl[0] !== 1'b0 || irdy[0] !== 1'b1 || tot_of(0) !== 8'd0 || ovf[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid vld/rdy/tot/ovf=%b/%b/%0d/%b need 0/1/0/0", ovl[0], irdy[0], tot_of(0), ovf[0]);
    end
    seen_n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, i < 4, 1, 1'b1);
      step(0);
    end
    n_cmp++;
    if (seen_n !== 1 || seen_tot !== 8'd4) begin
      n_bad++;
      $display("FAIL rstmid_next cycles/tot=%0d/%0d need 1/4", seen_n, seen_tot);
    end
    // Reset while a finished total is waiting for the consumer.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 2, 1'b0);
      step(0);
    end
    rst = 1'b1;
    drive(0, 1'b0, 0, 1'b0);
    step(0);
    rst = 1'b0;
    n_cmp++;
    if (ovl[0] !== 1'b0 || irdy[0] !== 1'b1 || tot_of(0) !== 8'd0 || sbq[0].size() != 0) begin
      n_bad++;
      $display("FAIL rstdone vld/rdy/tot=%b/%b/%0d need 0/1/0", ovl[0], irdy[0], tot_of(0));
    end
    drive(0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_count1();
    bit         exp_v [4] = '{1, 0, 1, 0};
    logic [7:0] exp_t [4] = '{8'd6, 8'd6, 8'd5, 8'd5};
    int         s     [4] = '{6, 5, 5, 0};
    bit         v     [4] = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      drive(2, v[i], s[i], 1'b1);
      step(2);
      n_cmp++;
      if (ovl[2] !== exp_v[i] || irdy[2] !== !exp_v[i] || tot_of(2) !== exp_t[i]) begin
        n_bad++;
        $display("FAIL cnt1[%0d] vld/rdy/tot=%b/%b/%0d need %b/%b/%0d", i, ovl[2], irdy[2], tot_of(2), exp_v[i], !exp_v[i], exp_t[i]);
      end
      if (m_done[2]) begin
        n_cmp++;
        if (tot_of(2) !== sbq[2][0].tot || ovf[2] !== sbq[2][0].ovf) begin
          n_bad++;
          $display("FAIL cnt1_sb[%0d] tot/ovf=%0d/%b need %0d/%b", i, tot_of(2), ovf[2], sbq[2][0].tot, sbq[2][0].ovf);
        end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    iv   = '0;
    cy   = '0;
    ordy = '1;
    for (int j = 0; j < 3; j++) begin
      sm[j] = 2'b00; m_sum[j] = 0; m_cnt[j] = 0; m_done[j] = 0;
    end
    seen_n = 0; seen_tot = '0; seen_ovf = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_count1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
